// File: rtl/trng_word_assembler.sv
// trng_word_assembler
//   Collects raw oscillator samples and removes bias with a von Neumann
//   corrector. Samples are taken as pairs: "01" gives bit 0, "10" gives bit 1,
//   and "00"/"11" are dropped. Thirty-two accepted bits make one word. After
//   each delivered word the block waits HOLDOFF idle cycles. A repetition-count
//   health test watches the raw stream and locks the block in FAIL until reset.
//
// Parameters
//   RCT_CUTOFF : run length of identical raw bits that counts as a failure (2..255)
//   HOLDOFF    : idle cycles after each delivered word (0..65535)
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   enable        in   level; permits word collection
//   raw_bit       in   raw entropy sample
//   raw_valid     in   raw_bit is valid this cycle
//   random_number out  32-bit conditioned word, changes only with ready
//   ready         out  one-cycle pulse; random_number is new
//   health_fail   out  sticky repetition-count failure flag
module trng_word_assembler #(
    parameter int unsigned RCT_CUTOFF = 32,
    parameter int unsigned HOLDOFF    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        raw_bit,
    input  logic        raw_valid,
    output logic [31:0] random_number,
    output logic        ready,
    output logic        health_fail
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_PRESENT = 3'd2,
        S_HOLDOFF = 3'd3,
        S_FAIL    = 3'd4
    } state_t;

    localparam logic [7:0]  CUT       = 8'(RCT_CUTOFF);
    localparam logic        HOLD_EN   = (HOLDOFF != 0);
    localparam logic [15:0] HOLD_LOAD = (HOLDOFF == 0) ? 16'd0 : 16'(HOLDOFF - 1);

    state_t      state_r;
    state_t      state_next;

    // The 32nd bit goes straight into random_number, so only 31 bits are kept.
    logic [30:0] shift_r;
    logic [5:0]  bit_cnt_r;
    logic        half_r;
    logic        first_r;
    logic [15:0] hold_cnt_r;

    logic        last_r;
    logic        seen_r;
    logic [7:0]  run_r;

    logic        rct_active_s;
    logic        run_same_s;
    logic [7:0]  run_next_s;
    logic        rct_trip_s;
    logic        pair_ok_s;
    logic        accept_s;
    logic        word_done_s;
    logic [31:0] shift_next_s;

    assign rct_active_s = raw_valid && ((state_r == S_COLLECT) ||
                                        (state_r == S_PRESENT) ||
                                        (state_r == S_HOLDOFF));
    assign run_same_s   = seen_r && (raw_bit == last_r);
    assign run_next_s   = !run_same_s      ? 8'd1 :
                          (run_r >= CUT)   ? CUT  : (run_r + 8'd1);
    assign rct_trip_s   = rct_active_s && (run_next_s == CUT);
    // Second sample of a pair that differs from the first: the pair yields first_r.
    assign pair_ok_s    = raw_valid && half_r && (first_r != raw_bit);
    assign shift_next_s = {shift_r, first_r};

    // Next-state decode; a health-test trip always overrides word completion.
    always_comb begin
        state_next  = state_r;
        accept_s    = 1'b0;
        word_done_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (enable) state_next = S_COLLECT;
                else        state_next = S_IDLE;
            end
            S_COLLECT: begin
                if (rct_trip_s) begin
                    state_next = S_FAIL;
                end else if (!enable) begin
                    state_next = S_IDLE;
                end else if (pair_ok_s) begin
                    accept_s = 1'b1;
                    if (bit_cnt_r == 6'd31) begin
                        word_done_s = 1'b1;
                        state_next  = S_PRESENT;
                    end else begin
                        state_next = S_COLLECT;
                    end
                end else begin
                    state_next = S_COLLECT;
                end
            end
            S_PRESENT: begin
                if (rct_trip_s)   state_next = S_FAIL;
                else if (HOLD_EN) state_next = S_HOLDOFF;
                else if (enable)  state_next = S_COLLECT;
                else              state_next = S_IDLE;
            end
            S_HOLDOFF: begin
                if (rct_trip_s)              state_next = S_FAIL;
                else if (hold_cnt_r != 16'd0) state_next = S_HOLDOFF;
                else if (enable)             state_next = S_COLLECT;
                else                         state_next = S_IDLE;
            end
            S_FAIL: begin
                state_next = S_FAIL;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_next;
    end

    // Pair register, bit counter and partial word; cleared whenever not collecting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_r    <= 1'b0;
            first_r   <= 1'b0;
            bit_cnt_r <= 6'd0;
            shift_r   <= 31'd0;
        end else if (state_r != S_COLLECT) begin
            half_r    <= 1'b0;
            first_r   <= 1'b0;
            bit_cnt_r <= 6'd0;
            shift_r   <= 31'd0;
        end else if (raw_valid && enable) begin
            half_r <= ~half_r;
            if (!half_r) first_r <= raw_bit;
            if (accept_s) begin
                shift_r   <= shift_next_s[30:0];
                bit_cnt_r <= bit_cnt_r + 6'd1;
            end
        end
    end

    // Holdoff counter: loaded while presenting, counts down to zero in HOLDOFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= 16'd0;
        end else if (state_r == S_PRESENT) begin
            hold_cnt_r <= HOLD_LOAD;
        end else if ((state_r == S_HOLDOFF) && (hold_cnt_r != 16'd0)) begin
            hold_cnt_r <= hold_cnt_r - 16'd1;
        end
    end

    // Repetition-count tracking; IDLE forgets history so the next sample starts a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= 1'b0;
            seen_r <= 1'b0;
            run_r  <= 8'd0;
        end else if (state_r == S_IDLE) begin
            last_r <= 1'b0;
            seen_r <= 1'b0;
            run_r  <= 8'd0;
        end else if (rct_active_s) begin
            last_r <= raw_bit;
            seen_r <= 1'b1;
            run_r  <= run_next_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random_number <= 32'd0;
            ready         <= 1'b0;
            health_fail   <= 1'b0;
        end else begin
            if (word_done_s) random_number <= shift_next_s;
            ready       <= word_done_s;
            health_fail <= health_fail | rct_trip_s;
        end
    end

endmodule

// File: tb/tb_trng_word_assembler.sv
// Bench for trng_word_assembler: two instances (HOLDOFF=0 and HOLDOFF=4).
// Each expected word and the negedge at which its ready pulse must appear are
// queued when the completing sample is driven; a negedge monitor pops and
// compares, and flags any ready pulse with nothing queued.
module tb_trng_word_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en0, bit0, val0, en4, bit4, val4;
    logic [31:0] rn0, rn4;
    logic        rdy0, rdy4, hf0, hf4;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;

    typedef struct {
        logic [31:0] word;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    trng_word_assembler #(.RCT_CUTOFF(32), .HOLDOFF(0)) dut0 (
        .clk(clk), .rst(rst), .enable(en0), .raw_bit(bit0), .raw_valid(val0),
        .random_number(rn0), .ready(rdy0), .health_fail(hf0)
    );

    trng_word_assembler #(.RCT_CUTOFF(32), .HOLDOFF(4)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .raw_bit(bit4), .raw_valid(val4),
        .random_number(rn4), .ready(rdy4), .health_fail(hf4)
    );

    // Compare one observed value against its expectation.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Ready monitor and scoreboard for both instances.
    always @(negedge clk) begin
        exp_t e;
        ncyc = ncyc + 1;
        if (!rst && rdy0) begin
            if (q0.size() == 0) begin
                check_eq("dut0_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                check_eq("dut0_word", rn0, e.word);
                check_eq("dut0_ready_cycle", ncyc, e.cyc);
            end
        end
        if (!rst && rdy4) begin
            if (q4.size() == 0) begin
                check_eq("dut4_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                check_eq("dut4_word", rn4, e.word);
                check_eq("dut4_ready_cycle", ncyc, e.cyc);
            end
        end
    end

    // Drive one valid raw sample into the selected instance.
    task automatic smp(input int d, input logic b);
        if (d == 0) begin
            bit0 = b;
            val0 = 1'b1;
        end else begin
            bit4 = b;
            val4 = 1'b1;
        end
        @(posedge clk);
        #1;
        val0 = 1'b0;
        val4 = 1'b0;
    endtask

    // Drive a pair, p[1] first.
    task automatic pair(input int d, input logic [1:0] p);
        smp(d, p[1]);
        smp(d, p[0]);
    endtask

    // Queue a word whose ready pulse must show at the next negedge.
    task automatic expect_word(input int d, input logic [31:0] w);
        exp_t e;
        e.word = w;
        e.cyc  = ncyc + 1;
        if (d == 0) q0.push_back(e);
        else        q4.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en0 = 1'b0; bit0 = 1'b0; val0 = 1'b0;
        en4 = 1'b0; bit4 = 1'b0; val4 = 1'b0;
        idle(2);
        check_eq("rst_rn0", rn0, 32'd0);
        check_eq("rst_rdy0", {31'd0, rdy0}, 32'd0);
        check_eq("rst_hf0", {31'd0, hf0}, 32'd0);
        check_eq("rst_rn4", rn4, 32'd0);
        check_eq("rst_rdy4", {31'd0, rdy4}, 32'd0);
        check_eq("rst_hf4", {31'd0, hf4}, 32'd0);
        rst = 1'b0;

        // All "10" pairs give all ones.
        en0 = 1'b1;
        idle(1);
        repeat (32) pair(0, 2'b10);
        expect_word(0, 32'hFFFF_FFFF);
        idle(2);
        check_eq("hold_after_word", rn0, 32'hFFFF_FFFF);

        // First accepted bit lands in bit 31.
        repeat (16) pair(0, 2'b01);
        repeat (16) pair(0, 2'b10);
        expect_word(0, 32'h0000_FFFF);
        idle(2);

        // Same word with discarded "00"/"11" pairs interleaved.
        for (int i = 0; i < 32; i++) begin
            pair(0, 2'b00);
            pair(0, 2'b11);
            pair(0, (i < 16) ? 2'b01 : 2'b10);
        end
        expect_word(0, 32'h0000_FFFF);
        idle(2);

        // Abort after 20 accepted bits; the partial word must vanish.
        repeat (20) pair(0, 2'b10);
        en0 = 1'b0;
        idle(2);
        check_eq("hold_in_idle", rn0, 32'h0000_FFFF);
        en0 = 1'b1;
        idle(1);
        repeat (32) pair(0, 2'b01);
        expect_word(0, 32'h0000_0000);
        idle(2);

        // Repetition-count failure on 32 identical raw bits.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        repeat (31) smp(0, 1'b1);
        check_eq("rct_below_cutoff", {31'd0, hf0}, 32'd0);
        smp(0, 1'b1);
        check_eq("rct_trip", {31'd0, hf0}, 32'd1);
        en0 = 1'b0;
        idle(3);
        en0 = 1'b1;
        repeat (32) pair(0, 2'b10);
        idle(2);
        check_eq("fail_sticky", {31'd0, hf0}, 32'd1);
        check_eq("fail_word_held", rn0, 32'd0);
        en0 = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rst_clears_fail", {31'd0, hf0}, 32'd0);
        idle(1);
        rst = 1'b0;

        // HOLDOFF=4: one PRESENT cycle plus four holdoff cycles ignore samples.
        en4 = 1'b1;
        idle(1);
        repeat (32) pair(4, 2'b10);
        expect_word(4, 32'hFFFF_FFFF);
        smp(4, 1'b1); smp(4, 1'b0); smp(4, 1'b1); smp(4, 1'b0); smp(4, 1'b1);
        repeat (32) pair(4, 2'b10);
        expect_word(4, 32'hFFFF_FFFF);
        smp(4, 1'b1); smp(4, 1'b0); smp(4, 1'b1); smp(4, 1'b0); smp(4, 1'b1);
        repeat (10) pair(4, 2'b10);
        rst = 1'b1;
        #1;
        check_eq("midrst_rn4", rn4, 32'd0);
        check_eq("midrst_rdy4", {31'd0, rdy4}, 32'd0);
        check_eq("midrst_hf4", {31'd0, hf4}, 32'd0);
        idle(1);
        rst = 1'b0;
        idle(1);
        repeat (32) pair(4, 2'b01);
        expect_word(4, 32'h0000_0000);
        idle(4);

        check_eq("dut0_pending", q0.size(), 32'd0);
        check_eq("dut4_pending", q4.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
